// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous shadow load.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dps,
    input  logic                    load,
    output logic                    load_ack,
    output logic [3:0]              num,
    output logic                    dp_out,
    output logic [N_DIGITS-1:0]     sel,
    output logic                    frame_done
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t                  state, state_n;
    logic [PW-1:0]           presc, presc_n;
    logic [IW-1:0]           idx, idx_n;
    logic [4*N_DIGITS-1:0]   shadow_d, shadow_d_n, src_d;
    logic [N_DIGITS-1:0]     shadow_p, shadow_p_n, src_p;
    logic [N_DIGITS-1:0]     sel_n;
    logic [3:0]              num_n;
    logic                    dp_n, ack_n, fd_n;
    logic                    wrap, boundary, cap;

    function automatic logic [3:0] digit_code(
        input logic [4*N_DIGITS-1:0] v,
        input logic [IW-1:0]         i
    );
        logic [3:0] d;
`ifdef SEG_SCAN_LZB_EN
        logic z;
`endif
        d = v[{i, 2'b00} +: 4];
`ifdef SEG_SCAN_LZB_EN
        // Blank only when this digit and every more significant one are zero.
        z = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(i) && v[4*j +: 4] != 4'h0) begin
                z = 1'b0;
            end
        end
        if (i != '0 && z) begin
            d = 4'hF;
        end
`endif
        return d;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            idx        <= '0;
            shadow_d   <= '0;
            shadow_p   <= '0;
            sel        <= '1;
            num        <= 4'hF;
            dp_out     <= 1'b0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            idx        <= idx_n;
            shadow_d   <= shadow_d_n;
            shadow_p   <= shadow_p_n;
            sel        <= sel_n;
            num        <= num_n;
            dp_out     <= dp_n;
            load_ack   <= ack_n;
            frame_done <= fd_n;
        end
    end

    always_comb begin
        state_n    = state;
        presc_n    = presc;
        idx_n      = idx;
        shadow_d_n = shadow_d;
        shadow_p_n = shadow_p;
        sel_n      = sel;
        num_n      = num;
        dp_n       = dp_out;
        ack_n      = 1'b0;
        fd_n       = 1'b0;

        wrap     = (presc == PW'(SCAN_DIV - 1));
        boundary = (state != IDLE) && wrap
                   && (idx == IW'(N_DIGITS - 1));
        // Blocking on load_ack keeps a load held through its ack cycle from re-capturing.
        cap      = load && !load_ack
                   && ((state == IDLE) || boundary);
        src_d    = cap ? digits : shadow_d;
        src_p    = cap ? dps : shadow_p;

        if (cap) begin
            shadow_d_n = digits;
            shadow_p_n = dps;
            ack_n      = 1'b1;
        end

        unique case (state)
            IDLE: begin
                presc_n = '0;
                idx_n   = '0;
                sel_n   = '1;
                num_n   = 4'hF;
                dp_n    = 1'b0;
                if (enable) begin
                    state_n = BLANK;
                    num_n   = digit_code(src_d, '0);
                    dp_n    = src_p[0];
                end
            end
            BLANK, DRIVE: begin
                if (!enable) begin
                    state_n = IDLE;
                    presc_n = '0;
                    idx_n   = '0;
                    sel_n   = '1;
                    num_n   = 4'hF;
                    dp_n    = 1'b0;
                end else if (wrap) begin
                    state_n = BLANK;
                    presc_n = '0;
                    idx_n   = boundary ? '0 : idx + 1'b1;
                    sel_n   = '1;
                    num_n   = digit_code(src_d, idx_n);
                    dp_n    = src_p[idx_n];
                    fd_n    = boundary;
                end else begin
                    presc_n = presc + 1'b1;
                    if (int'(presc) + 1 >= BLANK_CYCLES) begin
                        state_n    = DRIVE;
                        sel_n      = '1;
                        sel_n[idx] = 1'b0;
                    end else begin
                        state_n = BLANK;
                        sel_n   = '1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
